mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares one single-port memory between the cpu instruction-fetch port and its data port.
//  Sits between cpu (Instr/PC and ReadData/ALUResult/WriteData/MemWrite) and a unified memory.
//  Arbitrates simultaneous requests round-robin and issues one memory transaction at a time.
//  Returns read data or a write-ack to the winner, and aborts transactions on memory timeout.
// PARAMETERS
//  AW       32  address width
//  DW       32  data width
//  TIMEOUT  15  busy cycles without m_ready before abort; 0 disables timeout; max 255
// PORTS
//  clk       in   1   clock, rising edge
//  reset     in   1   asynchronous, active-high reset
//  i_req     in   1   fetch request; held until i_gnt seen; read only
//  i_addr    in   AW  fetch address (PC)
//  i_gnt     out  1   1-cycle pulse: fetch request accepted
//  i_rvalid  out  1   1-cycle pulse: fetch complete, i_rdata valid
//  i_rdata   out  DW  fetched instruction
//  i_err     out  1   qualifies i_rvalid: fetch aborted by timeout
//  d_req     in   1   data request; held until d_gnt seen
//  d_we      in   1   1 = write (MemWrite), 0 = read
//  d_addr    in   AW  data address (ALUResult)
//  d_wdata   in   DW  store data (WriteData)
//  d_gnt     out  1   1-cycle pulse: data request accepted
//  d_rvalid  out  1   1-cycle pulse: read data valid, or write acknowledged
//  d_rdata   out  DW  load data (ReadData); 0 for writes
//  d_err     out  1   qualifies d_rvalid: data access aborted by timeout
//  m_req     out  1   memory request; held high until m_ready or abort
//  m_we      out  1   memory write enable
//  m_addr    out  AW  memory address; stable while m_req=1
//  m_wdata   out  DW  memory write data; stable while m_req=1
//  m_ready   in   1   memory completes the transaction in this cycle
//  m_rdata   in   DW  memory read data; valid when m_ready=1
//  busy      out  1   1 while a transaction is in flight (state != IDLE)
// BEHAVIOUR
//  - Reset: all outputs 0, state=IDLE, last_d=0, timeout counter 0. All outputs are registered.
//  - Reset mid-transaction: in-flight access is dropped at once. No rvalid, gnt or err is issued.
//  - FSM states: IDLE, I_BUSY, D_BUSY.
//  - IDLE, edge with any req: pick a winner and latch its addr/we/wdata into m_*.
//    Next cycle: m_req=1, winner gnt=1 for exactly 1 cycle, state=X_BUSY. Fetch sets m_we=0.
//  - Arbitration: only one req -> it wins. Both req -> d wins if last_d=0, else i wins.
//    last_d updates on every grant: 1 if d won, 0 if i won.
//  - Requests are ignored in any BUSY state. The requester drops req after seeing gnt.
//    A req still high at a later IDLE edge is a new request.
//  - X_BUSY, edge with m_ready=1: capture m_rdata (forced to 0 if m_we=1).
//    Next cycle: x_rvalid=1, x_err=0, m_req=0, state=IDLE.
//  - Minimum latency is req sampled at edge N -> m_req in cycle N+1 -> rvalid in cycle N+2
//    when m_ready=1 in cycle N+1. Peak throughput is 1 transaction per 2 cycles.
//  - Timeout: counter clears on grant and increments each BUSY cycle with m_ready=0.
//    When it reaches TIMEOUT (TIMEOUT>0): x_rvalid=1, x_err=1, x_rdata=0, m_req=0, state=IDLE.
//    m_ready=1 in the same cycle as timeout: the access completes normally and err is not set.
//  - x_rdata holds its last value between rvalid pulses. gnt, rvalid and err are never high for both ports at once.
// TESTING
//  - Reset: reset=1 mid-D_BUSY -> all outputs 0 at once, no d_rvalid after release, busy=0.
//  - Single fetch: i_req, i_addr=0x10; m_ready=1 one cycle after m_req with m_rdata=0xE3A01005
//    -> i_gnt pulse, m_addr=0x10, m_we=0, then i_rvalid with i_rdata=0xE3A01005.
//  - Store: d_we=1, d_addr=0x80, d_wdata=0xCAFEF00D, m_ready after 3 cycles
//    -> m_we=1, m_wdata stable for 3 cycles, d_rvalid=1, d_rdata=0, d_err=0.
//  - Contention: i_req and d_req held high for 4 transactions from reset -> grant order d,i,d,i.
//  - Timeout: TIMEOUT=4, m_ready held 0 -> d_rvalid=1, d_err=1 after 4 busy cycles, m_req=0.
//    Repeat with m_ready=1 in the 4th cycle -> d_err=0.
//  - Back-to-back: zero-wait memory with continuous fetches -> one i_rvalid every 2 cycles.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one single-port memory between
// the instruction-fetch port and the data port.
module mem_port_arbiter #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 15
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_req,
    input  logic [AW-1:0] i_addr,
    output logic          i_gnt,
    output logic          i_rvalid,
    output logic [DW-1:0] i_rdata,
    output logic          i_err,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_gnt,
    output logic          d_rvalid,
    output logic [DW-1:0] d_rdata,
    output logic          d_err,
    output logic          m_req,
    output logic          m_we,
    output logic [AW-1:0] m_addr,
    output logic [DW-1:0] m_wdata,
    input  logic          m_ready,
    input  logic [DW-1:0] m_rdata,
    output logic          busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        I_BUSY = 2'd1,
        D_BUSY = 2'd2
    } state_t;

    localparam logic [7:0] TO = 8'(TIMEOUT);

    state_t        state_q, state_d;
    logic          last_d_q, last_d_d;
    logic [7:0]    cnt_q, cnt_d;
    logic          m_req_q, m_req_d;
    logic          m_we_q, m_we_d;
    logic [AW-1:0] m_addr_q, m_addr_d;
    logic [DW-1:0] m_wdata_q, m_wdata_d;
    logic          i_gnt_q, i_gnt_d;
    logic          d_gnt_q, d_gnt_d;
    logic          i_rvalid_q, i_rvalid_d;
    logic          d_rvalid_q, d_rvalid_d;
    logic          i_err_q, i_err_d;
    logic          d_err_q, d_err_d;
    logic [DW-1:0] i_rdata_q, i_rdata_d;
    logic [DW-1:0] d_rdata_q, d_rdata_d;
    logic          busy_q, busy_d;

    logic          win_d, win_i, tout;
    logic [DW-1:0] rd_val;

    // Data wins when alone or when fetch won last time
    assign win_d  = d_req && (!i_req || !last_d_q);
    assign win_i  = i_req && !win_d;
    assign tout   = !m_ready && (TO != 8'd0)
                    && ((cnt_q + 8'd1) == TO);
    assign rd_val = m_we_q ? '0 : m_rdata;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (win_d)      state_d = D_BUSY;
                else if (win_i) state_d = I_BUSY;
            end
            I_BUSY, D_BUSY: begin
                if (m_ready || tout) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Output and datapath next values
    always_comb begin
        last_d_d   = last_d_q;
        cnt_d      = cnt_q;
        m_req_d    = m_req_q;
        m_we_d     = m_we_q;
        m_addr_d   = m_addr_q;
        m_wdata_d  = m_wdata_q;
        i_rdata_d  = i_rdata_q;
        d_rdata_d  = d_rdata_q;
        i_gnt_d    = 1'b0;
        d_gnt_d    = 1'b0;
        i_rvalid_d = 1'b0;
        d_rvalid_d = 1'b0;
        i_err_d    = 1'b0;
        d_err_d    = 1'b0;
        busy_d     = (state_d != IDLE);
        unique case (state_q)
            IDLE: begin
                if (win_d || win_i) begin
                    m_req_d   = 1'b1;
                    cnt_d     = 8'd0;
                    last_d_d  = win_d;
                    i_gnt_d   = win_i;
                    d_gnt_d   = win_d;
                    m_we_d    = win_d ? d_we : 1'b0;
                    m_addr_d  = win_d ? d_addr : i_addr;
                    m_wdata_d = win_d ? d_wdata : '0;
                end
            end
            I_BUSY, D_BUSY: begin
                if (m_ready || tout) begin
                    m_req_d = 1'b0;
                    if (state_q == I_BUSY) begin
                        i_rvalid_d = 1'b1;
                        i_err_d    = !m_ready;
                        i_rdata_d  = m_ready ? rd_val : '0;
                    end else begin
                        d_rvalid_d = 1'b1;
                        d_err_d    = !m_ready;
                        d_rdata_d  = m_ready ? rd_val : '0;
                    end
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: ;
        endcase
    end

    // Registered outputs and arbitration history
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_d_q   <= 1'b0;
            cnt_q      <= 8'd0;
            m_req_q    <= 1'b0;
            m_we_q     <= 1'b0;
            m_addr_q   <= '0;
            m_wdata_q  <= '0;
            i_gnt_q    <= 1'b0;
            d_gnt_q    <= 1'b0;
            i_rvalid_q <= 1'b0;
            d_rvalid_q <= 1'b0;
            i_err_q    <= 1'b0;
            d_err_q    <= 1'b0;
            i_rdata_q  <= '0;
            d_rdata_q  <= '0;
            busy_q     <= 1'b0;
        end else begin
            last_d_q   <= last_d_d;
            cnt_q      <= cnt_d;
            m_req_q    <= m_req_d;
            m_we_q     <= m_we_d;
            m_addr_q   <= m_addr_d;
            m_wdata_q  <= m_wdata_d;
            i_gnt_q    <= i_gnt_d;
            d_gnt_q    <= d_gnt_d;
            i_rvalid_q <= i_rvalid_d;
            d_rvalid_q <= d_rvalid_d;
            i_err_q    <= i_err_d;
            d_err_q    <= d_err_d;
            i_rdata_q  <= i_rdata_d;
            d_rdata_q  <= d_rdata_d;
            busy_q     <= busy_d;
        end
    end

    assign i_gnt    = i_gnt_q;
    assign d_gnt    = d_gnt_q;
    assign i_rvalid = i_rvalid_q;
    assign d_rvalid = d_rvalid_q;
    assign i_err    = i_err_q;
    assign d_err    = d_err_q;
    assign i_rdata  = i_rdata_q;
    assign d_rdata  = d_rdata_q;
    assign m_req    = m_req_q;
    assign m_we     = m_we_q;
    assign m_addr   = m_addr_q;
    assign m_wdata  = m_wdata_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: fetch, store,
// contention, timeout, back-to-back and async reset.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        i_req, d_req, d_we, m_ready;
    logic [31:0] i_addr, d_addr, d_wdata, m_rdata;
    logic        i_gnt, i_rvalid, i_err;
    logic        d_gnt, d_rvalid, d_err;
    logic [31:0] i_rdata, d_rdata;
    logic        m_req, m_we, busy;
    logic [31:0] m_addr, m_wdata;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.AW(32), .DW(32), .TIMEOUT(4)) dut (
        .clk(clk), .reset(reset),
        .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt),
        .i_rvalid(i_rvalid), .i_rdata(i_rdata), .i_err(i_err),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr),
        .d_wdata(d_wdata), .d_gnt(d_gnt), .d_rvalid(d_rvalid),
        .d_rdata(d_rdata), .d_err(d_err),
        .m_req(m_req), .m_we(m_we), .m_addr(m_addr),
        .m_wdata(m_wdata), .m_ready(m_ready), .m_rdata(m_rdata),
        .busy(busy)
    );

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    function automatic logic [31:0] all_out();
        return {19'd0, i_gnt, i_rvalid, i_err, d_gnt,
                d_rvalid, d_err, m_req, m_we, busy,
                |i_rdata, |d_rdata, |m_addr, |m_wdata};
    endfunction

    task automatic do_reset();
        reset = 1'b1;
        cyc(); cyc();
        reset = 1'b0;
    endtask

    initial begin
        logic [3:0] order;
        int         ng;
        logic [31:0] wd;
        reset = 1'b1;
        i_req = 0; d_req = 0; d_we = 0; m_ready = 0;
        i_addr = 0; d_addr = 0; d_wdata = 0; m_rdata = 0;
        do_reset();
        chk("reset_outs", all_out(), 32'd0);

        // single fetch
        i_req = 1; i_addr = 32'h10;
        cyc();
        chk("f_gnt", {i_gnt, d_gnt, m_req, m_we, busy}, 32'b10101);
        chk("f_addr", m_addr, 32'h10);
        i_req = 0; m_ready = 1; m_rdata = 32'hE3A01005;
        cyc();
        chk("f_rv", {i_rvalid, i_err, m_req, busy, i_gnt}, 32'b10000);
        chk("f_rdata", i_rdata, 32'hE3A01005);
        m_ready = 0; m_rdata = 32'h12345678;
        cyc();
        chk("f_hold", {31'd0, i_rvalid}, 32'd0);
        chk("f_hold_d", i_rdata, 32'hE3A01005);

        // store with 3-cycle memory
        d_req = 1; d_we = 1; d_addr = 32'h80; d_wdata = 32'hCAFEF00D;
        cyc();
        chk("s_gnt", {i_gnt, d_gnt, m_req, m_we}, 32'b0111);
        chk("s_addr", m_addr, 32'h80);
        d_req = 0; d_wdata = 32'h0;
        for (int k = 0; k < 3; k++) begin
            m_ready = (k == 2);
            wd = m_wdata;
            chk("s_wdata", wd, 32'hCAFEF00D);
            cyc();
            if (k < 2) chk("s_wait", {d_rvalid, m_req}, 32'b01);
        end
        chk("s_ack", {d_rvalid, d_err, m_req, busy}, 32'b1000);
        chk("s_rdata", d_rdata, 32'h0);
        m_ready = 0;

        // contention from reset: d,i,d,i
        do_reset();
        i_req = 1; d_req = 1; d_we = 0;
        i_addr = 32'h100; d_addr = 32'h200;
        m_ready = 1; m_rdata = 32'hA5A5A5A5;
        order = 4'd0; ng = 0;
        for (int c = 0; c < 20 && ng < 4; c++) begin
            cyc();
            chk("c_excl", {30'd0, i_gnt & d_gnt, i_rvalid & d_rvalid}, 32'd0);
            if (d_gnt || i_gnt) begin
                order = {order[2:0], d_gnt};
                chk("c_addr", m_addr, d_gnt ? 32'h200 : 32'h100);
                ng++;
            end
        end
        chk("c_order", {28'd0, order}, 32'b1010);
        chk("c_count", ng, 32'd4);
        i_req = 0; d_req = 0;
        cyc(); cyc();
        chk("c_drdata", d_rdata, 32'hA5A5A5A5);

        // timeout with memory stalled
        m_ready = 0; m_rdata = 32'h5555AAAA;
        d_req = 1; d_addr = 32'h300;
        cyc();
        chk("t_gnt", {30'd0, d_gnt, m_req}, 32'b11);
        d_req = 0;
        for (int k = 0; k < 4; k++) begin
            cyc();
            if (k < 3) chk("t_wait", {d_rvalid, m_req}, 32'b01);
        end
        chk("t_abort", {d_rvalid, d_err, m_req, busy}, 32'b1100);
        chk("t_rdata", d_rdata, 32'h0);
        cyc();
        chk("t_clr", {30'd0, d_rvalid, d_err}, 32'd0);

        // m_ready in the would-be timeout cycle
        d_req = 1;
        cyc();
        d_req = 0;
        for (int k = 0; k < 4; k++) begin
            m_ready = (k == 3);
            cyc();
        end
        chk("t2_done", {d_rvalid, d_err, m_req}, 32'b100);
        chk("t2_rdata", d_rdata, 32'h5555AAAA);
        m_ready = 0;
        cyc();

        // back-to-back fetches, zero-wait memory
        do_reset();
        i_req = 1; m_ready = 1; m_rdata = 32'h00C0FFEE;
        ng = 0;
        for (int c = 1; c <= 20; c++) begin
            cyc();
            chk("b_rv", {31'd0, i_rvalid}, {31'd0, (c % 2) == 0});
            if (i_rvalid) ng++;
        end
        chk("b_count", ng, 32'd10);
        i_req = 0; m_ready = 0;
        cyc(); cyc();

        // async reset in the middle of D_BUSY
        d_req = 1; d_we = 1; d_wdata = 32'h1; d_addr = 32'h44;
        cyc();
        d_req = 0;
        cyc();
        chk("r_busy", {30'd0, busy, m_req}, 32'b11);
        #2 reset = 1'b1;
        #1 chk("r_async", all_out(), 32'd0);
        m_ready = 1;
        cyc();
        reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            cyc();
            chk("r_after", {29'd0, d_rvalid, busy, d_err}, 32'd0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
